sm4_key_ctrl: RTL and testbench

SM4_KEY_CTRL -- requirements
Module: sm4_key_ctrl

---
 rtl/sm4_key_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sm4_key_ctrl.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_key_ctrl.sv
// sm4_key_ctrl: sequences SM4 key installation and block processing.
// Installs a host key, runs the key expander with a timeout, then passes
// blocks one at a time to the round core and returns each result through
// a valid/ready handshake.
// Ports:
//   clk, rst (synchronous, active-low)
//   key_load/key_in -> key_ack      host key request; ack is a 1-cycle pulse
//   key_ready, err_timeout          key status (err_timeout is sticky)
//   ke_en/ke_key <- ke_done         key expander control
//   blk_valid/blk_ready/blk_data/blk_encdec   input block handshake
//   core_start/core_data/core_encdec <- core_done/core_result   round core
//   res_valid/res_ready/res_data    result handshake
//   blk_count                       completed blocks since reset (wraps)
module sm4_key_ctrl #(
  parameter  int unsigned TO_CYCLES = 64,
  localparam int unsigned DW        = 128,
  localparam int unsigned TW        = 7,
  localparam int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [DW-1:0] key_in,
  output logic          key_ack,
  output logic          key_ready,
  output logic          ke_en,
  output logic [DW-1:0] ke_key,
  input  logic          ke_done,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic [DW-1:0] blk_data,
  input  logic          blk_encdec,
  output logic          core_start,
  output logic [DW-1:0] core_data,
  output logic          core_encdec,
  input  logic          core_done,
  input  logic [DW-1:0] core_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          err_timeout,
  output logic [CW-1:0] blk_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXPAND, S_KEYED, S_CRYPT, S_RESP, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] ke_key_q, ke_key_d;
  logic          ke_en_q, ke_en_d;
  logic          key_ack_q, key_ack_d;
  logic          key_ready_q, key_ready_d;
  logic          core_start_q, core_start_d;
  logic [DW-1:0] core_data_q, core_data_d;
  logic          core_encdec_q, core_encdec_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          err_timeout_q, err_timeout_d;
  logic [CW-1:0] blk_count_q, blk_count_d;

  // A key request still held in the cycle its ack is shown is the same
  // request, so it is not taken a second time.
  logic key_take;
  logic same_key;

  // Only the block-side ready is combinational: it must drop in the same
  // cycle a key request appears so the key wins.
  assign blk_ready = rst && (state_q == S_KEYED) && !key_load;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    ke_key_d      = ke_key_q;
    ke_en_d       = ke_en_q;
    key_ack_d     = 1'b0;
    key_ready_d   = key_ready_q;
    core_start_d  = 1'b0;
    core_data_d   = core_data_q;
    core_encdec_d = core_encdec_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    err_timeout_d = err_timeout_q;
    blk_count_d   = blk_count_q;

    key_take = key_load && !key_ack_q &&
               ((state_q == S_IDLE) || (state_q == S_KEYED) || (state_q == S_ERR));
    same_key = (state_q == S_KEYED) && (key_in == ke_key_q);

    case (state_q)
      S_IDLE, S_KEYED, S_ERR: begin
        if (key_take) begin
          key_ack_d = 1'b1;
          // Reloading the installed key needs no re-expansion.
          if (!same_key) begin
            ke_key_d      = key_in;
            err_timeout_d = 1'b0;
            key_ready_d   = 1'b0;
            ke_en_d       = 1'b1;
            timer_d       = '0;
            state_d       = S_EXPAND;
          end
        end else if (blk_valid && blk_ready) begin
          core_data_d   = blk_data;
          core_encdec_d = blk_encdec;
          core_start_d  = 1'b1;
          state_d       = S_CRYPT;
        end
      end
      S_EXPAND: begin
        timer_d = timer_q + TW'(1);
        if (ke_done && (timer_q < TW'(TO_CYCLES))) begin
          ke_en_d     = 1'b0;
          key_ready_d = 1'b1;
          timer_d     = '0;
          state_d     = S_KEYED;
        end else if (timer_q >= TW'(TO_CYCLES)) begin
          ke_en_d       = 1'b0;
          err_timeout_d = 1'b1;
          timer_d       = '0;
          state_d       = S_ERR;
        end
      end
      S_CRYPT: begin
        if (core_done) begin
          res_data_d  = core_result;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          blk_count_d = blk_count_q + CW'(1);
          state_d     = S_KEYED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      ke_key_q      <= '0;
      ke_en_q       <= 1'b0;
      key_ack_q     <= 1'b0;
      key_ready_q   <= 1'b0;
      core_start_q  <= 1'b0;
      core_data_q   <= '0;
      core_encdec_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      err_timeout_q <= 1'b0;
      blk_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ke_key_q      <= ke_key_d;
      ke_en_q       <= ke_en_d;
      key_ack_q     <= key_ack_d;
      key_ready_q   <= key_ready_d;
      core_start_q  <= core_start_d;
      core_data_q   <= core_data_d;
      core_encdec_q <= core_encdec_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      err_timeout_q <= err_timeout_d;
      blk_count_q   <= blk_count_d;
    end
  end

  assign key_ack     = key_ack_q;
  assign key_ready   = key_ready_q;
  assign ke_en       = ke_en_q;
  assign ke_key      = ke_key_q;
  assign core_start  = core_start_q;
  assign core_data   = core_data_q;
  assign core_encdec = core_encdec_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign err_timeout = err_timeout_q;
  assign blk_count   = blk_count_q;

endmodule

// File: tb/tb_sm4_key_ctrl.sv
// tb_sm4_key_ctrl: bench for sm4_key_ctrl with a behavioural key expander,
// a behavioural SM4 round core and an SM4 reference function.
module tb_sm4_key_ctrl;

  localparam int TO = 64;
  localparam logic [127:0] K0  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT0 = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [7:0] SBOX [0:255] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  logic         clk;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ack;
  logic         key_ready;
  logic         ke_en;
  logic [127:0] ke_key;
  logic         ke_done;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         blk_encdec;
  logic         core_start;
  logic [127:0] core_data;
  logic         core_encdec;
  logic         core_done;
  logic [127:0] core_result;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         err_timeout;
  logic [15:0]  blk_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural environment knobs.
  int   ke_lat   = 32;
  int   core_lat = 4;
  bit   ke_tie0  = 1'b0;
  bit   ke_force = 1'b0;
  bit   core_force = 1'b0;

  logic [127:0] cur_key   = '0;
  logic [15:0]  exp_count = '0;

  sm4_key_ctrl #(.TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .key_load(key_load), .key_in(key_in), .key_ack(key_ack),
    .key_ready(key_ready), .ke_en(ke_en), .ke_key(ke_key), .ke_done(ke_done),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_encdec(blk_encdec), .core_start(core_start), .core_data(core_data),
    .core_encdec(core_encdec), .core_done(core_done), .core_result(core_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_timeout(err_timeout), .blk_count(blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SM4 reference ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [127:0] sm4_ref(input logic [127:0] key,
                                           input logic [127:0] blk,
                                           input bit dec);
    logic [31:0] k  [0:35];
    logic [31:0] rk [0:31];
    logic [31:0] x  [0:35];
    logic [31:0] ck, t, r;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
      t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
      rk[i] = k[i+4];
    end
    x[0] = blk[127:96]; x[1] = blk[95:64]; x[2] = blk[63:32]; x[3] = blk[31:0];
    for (int i = 0; i < 32; i++) begin
      r = dec ? rk[31-i] : rk[i];
      t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ r);
      x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- environment models ----------------
  // Key expander: ke_done arrives ke_lat cycles after ke_en rises.
  initial begin
    int cnt;
    cnt = 0;
    ke_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      ke_done = ke_force;
      if (ke_en === 1'b1) begin
        if (!ke_tie0 && cnt == ke_lat) ke_done = 1'b1;
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Round core: result core_lat cycles after core_start, garbage otherwise.
  initial begin
    int cc;
    bit busy;
    logic [127:0] ckey, cdat;
    bit cdec;
    busy = 1'b0; cc = 0; ckey = '0; cdat = '0; cdec = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk); #2;
      core_done = core_force;
      core_result = rand128();
      if (!rst) begin
        busy = 1'b0;
      end else if (core_start === 1'b1) begin
        busy = 1'b1; cc = 0; ckey = ke_key; cdat = core_data; cdec = core_encdec;
      end
      if (busy) begin
        if (cc == core_lat) begin
          core_done = 1'b1;
          core_result = sm4_ref(ckey, cdat, cdec);
          busy = 1'b0;
        end else begin
          cc++;
        end
      end
    end
  end

  // ---------------- host helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input logic [127:0] k, input int lat);
    int n;
    ke_lat = lat; key_in = k; key_load = 1'b1; n = 0;
    do begin tick(); n++; end while (key_ack !== 1'b1 && n < 20);
    key_load = 1'b0;
    total++;
    if (key_ack !== 1'b1) begin bad++; $display("FAIL load_key_ack: key_ack=%b after %0d cycles, want 1", key_ack, n); end
    cur_key = k;
    n = 0;
    while (key_ready !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL load_key_ready: key_ready=%b after %0d cycles, want 1", key_ready, n); end
  endtask

  task automatic run_block(input logic [127:0] d, input bit ed, input int rdly,
                           output logic [127:0] r);
    int n;
    blk_data = d; blk_encdec = ed; blk_valid = 1'b1; n = 0;
    while (blk_ready !== 1'b1 && n < 50) begin tick(); n++; end
    total++;
    if (blk_ready !== 1'b1) begin bad++; $display("FAIL blk_accept: blk_ready=%b, want 1", blk_ready); end
    tick();
    blk_valid = 1'b0; blk_data = rand128();
    total++;
    if ({core_start, core_encdec, core_data} !== {1'b1, ed, d}) begin
      bad++; $display("FAIL core_issue: got start=%b ed=%b data=%h want 1 %b %h", core_start, core_encdec, core_data, ed, d);
    end
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin tick(); n++; end
    total++;
    if (res_valid !== 1'b1) begin bad++; $display("FAIL res_wait: res_valid=%b, want 1", res_valid); end
    r = res_data;
    repeat (rdly) tick();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    total++;
    if (res_valid !== 1'b0 || blk_count !== exp_count) begin
      bad++; $display("FAIL res_done: res_valid=%b blk_count=%h want 0 %h", res_valid, blk_count, exp_count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; key_load = 1'b1; key_in = rand128(); blk_valid = 1'b1;
    blk_data = rand128(); blk_encdec = 1'b1; res_ready = 1'b1;
    repeat (3) tick();
    total++;
    if ({key_ack, key_ready, ke_en, ke_key, core_start, core_data, core_encdec,
         res_valid, res_data, err_timeout, blk_count} !== '0) begin
      bad++; $display("FAIL reset_outputs: ack=%b rdy=%b en=%b core_start=%b res_valid=%b err=%b cnt=%h want all 0",
                      key_ack, key_ready, ke_en, core_start, res_valid, err_timeout, blk_count);
    end
    total++;
    if (blk_ready !== 1'b0) begin bad++; $display("FAIL reset_blk_ready: got %b want 0", blk_ready); end
    rst = 1'b1; key_load = 1'b0; blk_valid = 1'b0; res_ready = 1'b0;
    tick();
    total++;
    if ({key_ack, key_ready, ke_en, blk_ready, err_timeout} !== 5'b0) begin
      bad++; $display("FAIL idle_after_reset: ack=%b rdy=%b en=%b blk_ready=%b err=%b want 0",
                      key_ack, key_ready, ke_en, blk_ready, err_timeout);
    end
  endtask

  task automatic test_key_expand();
    int en, acks, n;
    ke_lat = 32; key_in = K0; key_load = 1'b1;
    tick();
    total++;
    if ({key_ack, ke_en, key_ready} !== 3'b110 || ke_key !== K0) begin
      bad++; $display("FAIL expand_accept: ack=%b en=%b rdy=%b key=%h want 1 1 0 %h", key_ack, ke_en, key_ready, ke_key, K0);
    end
    key_load = 1'b0; key_in = rand128(); cur_key = K0;
    en = 0; acks = 0; n = 0;
    while (ke_en === 1'b1 && n < 300) begin
      en++; if (key_ack === 1'b1) acks++;
      tick(); n++;
    end
    total++;
    if (en != 33) begin bad++; $display("FAIL expand_ke_en_cycles: got %0d want 33", en); end
    total++;
    if (acks != 1) begin bad++; $display("FAIL expand_ack_pulses: got %0d want 1", acks); end
    total++;
    if ({key_ready, blk_ready, err_timeout} !== 3'b110) begin
      bad++; $display("FAIL expand_keyed: rdy=%b blk_ready=%b err=%b want 1 1 0", key_ready, blk_ready, err_timeout);
    end
  endtask

  task automatic test_known_vector();
    logic [127:0] r, r2;
    core_lat = 6;
    run_block(K0, 1'b0, 0, r);
    total++;
    if (r !== CT0) begin bad++; $display("FAIL kat_encrypt: got %h want %h", r, CT0); end
    run_block(r, 1'b1, 1, r2);
    total++;
    if (r2 !== K0) begin bad++; $display("FAIL kat_decrypt: got %h want %h", r2, K0); end
    total++;
    if (blk_count !== 16'd2) begin bad++; $display("FAIL kat_count: got %0d want 2", blk_count); end
  endtask

  task automatic test_stray_done();
    ke_force = 1'b1; core_force = 1'b1;
    repeat (4) tick();
    ke_force = 1'b0; core_force = 1'b0;
    repeat (2) tick();
    total++;
    if ({ke_en, key_ready, res_valid, core_start, blk_ready} !== 5'b01001) begin
      bad++; $display("FAIL stray_done: en=%b rdy=%b res_valid=%b start=%b blk_ready=%b want 0 1 0 0 1",
                      ke_en, key_ready, res_valid, core_start, blk_ready);
    end
  endtask

  task automatic test_key_reload();
    int acks, en_hi, rdy_lo, en, n;
    logic [127:0] k1, k2, d, r;
    // Same key: acknowledge only.
    key_in = cur_key; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    acks = (key_ack === 1'b1) ? 1 : 0; en_hi = 0; rdy_lo = 0;
    repeat (6) begin
      if (ke_en !== 1'b0) en_hi++;
      if (key_ready !== 1'b1) rdy_lo++;
      tick();
      if (key_ack === 1'b1) acks++;
    end
    total++;
    if (acks != 1 || en_hi != 0 || rdy_lo != 0) begin
      bad++; $display("FAIL same_key: acks=%0d ke_en_hi=%0d ready_lo=%0d want 1 0 0", acks, en_hi, rdy_lo);
    end
    // Different key: full re-expansion.
    k1 = rand128(); ke_lat = int'($urandom_range(3, 20));
    key_in = k1; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    total++;
    if ({key_ack, key_ready, ke_en} !== 3'b101 || ke_key !== k1) begin
      bad++; $display("FAIL new_key_accept: ack=%b rdy=%b en=%b key=%h want 1 0 1 %h", key_ack, key_ready, ke_en, ke_key, k1);
    end
    en = 0; n = 0;
    while (ke_en === 1'b1 && n < 200) begin en++; tick(); n++; end
    total++;
    if (en != ke_lat + 1 || key_ready !== 1'b1) begin
      bad++; $display("FAIL new_key_expand: ke_en cycles=%0d rdy=%b want %0d 1", en, key_ready, ke_lat + 1);
    end
    cur_key = k1;
    d = rand128();
    run_block(d, 1'b0, 0, r);
    total++;
    if (r !== sm4_ref(k1, d, 1'b0)) begin bad++; $display("FAIL new_key_block: got %h want %h", r, sm4_ref(k1, d, 1'b0)); end
    // Key and block together: the key wins.
    k2 = rand128(); ke_lat = 5;
    blk_valid = 1'b1; blk_data = rand128(); blk_encdec = 1'b0;
    key_in = k2; key_load = 1'b1;
    #1;
    total++;
    if (blk_ready !== 1'b0) begin bad++; $display("FAIL key_vs_blk_ready: got %b want 0", blk_ready); end
    tick();
    key_load = 1'b0; blk_valid = 1'b0;
    total++;
    if ({key_ack, core_start, ke_en} !== 3'b101) begin
      bad++; $display("FAIL key_vs_blk: ack=%b start=%b en=%b want 1 0 1", key_ack, core_start, ke_en);
    end
    cur_key = k2;
    n = 0;
    while (key_ready !== 1'b1 && n < 50) begin tick(); n++; end
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL key_vs_blk_ready_wait: rdy=%b want 1", key_ready); end
  endtask

  task automatic test_timeout();
    int n, hi;
    // ke_done on the last allowed count still succeeds.
    load_key(rand128(), TO - 1);
    total++;
    if ({key_ready, err_timeout} !== 2'b10) begin
      bad++; $display("FAIL to_edge_ok: rdy=%b err=%b want 1 0", key_ready, err_timeout);
    end
    // Expander never answers.
    ke_tie0 = 1'b1;
    key_in = rand128(); key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n = 0;
    while (err_timeout !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (n != TO + 1) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", n, TO + 1); end
    total++;
    if ({ke_en, key_ready} !== 2'b00) begin bad++; $display("FAIL timeout_state: en=%b rdy=%b want 0 0", ke_en, key_ready); end
    blk_valid = 1'b1; blk_data = rand128(); hi = 0;
    repeat (5) begin if (blk_ready !== 1'b0 || core_start !== 1'b0) hi++; tick(); end
    blk_valid = 1'b0;
    total++;
    if (hi != 0) begin bad++; $display("FAIL err_blk_ready: cycles ready=%0d want 0", hi); end
    // ke_done exactly at the limit is too late.
    ke_tie0 = 1'b0; ke_lat = TO;
    key_in = rand128(); key_load = 1'b1;
    tick();
    key_load = 1'b0;
    total++;
    if ({key_ack, err_timeout, ke_en} !== 3'b101) begin
      bad++; $display("FAIL err_reload: ack=%b err=%b en=%b want 1 0 1", key_ack, err_timeout, ke_en);
    end
    n = 0;
    while (err_timeout !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (n != TO + 1 || key_ready !== 1'b0) begin
      bad++; $display("FAIL to_edge_late: latency=%0d rdy=%b want %0d 0", n, key_ready, TO + 1);
    end
    load_key(rand128(), int'($urandom_range(1, 30)));
    total++;
    if (err_timeout !== 1'b0) begin bad++; $display("FAIL err_recover: err=%b want 0", err_timeout); end
  endtask

  task automatic test_resp_hold();
    int n;
    logic [127:0] d, cap, e;
    core_lat = 3; d = rand128();
    blk_data = d; blk_encdec = 1'b1; blk_valid = 1'b1; n = 0;
    while (blk_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    blk_valid = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 50) begin tick(); n++; end
    cap = res_data; e = sm4_ref(cur_key, d, 1'b1);
    total++;
    if (cap !== e) begin bad++; $display("FAIL hold_result: got %h want %h", cap, e); end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (res_valid !== 1'b1 || res_data !== e || blk_count !== exp_count) begin
        bad++; $display("FAIL hold_cycle%0d: valid=%b data=%h cnt=%h want 1 %h %h", i, res_valid, res_data, blk_count, e, exp_count);
      end
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    total++;
    if (res_valid !== 1'b0 || blk_count !== exp_count) begin
      bad++; $display("FAIL hold_release: valid=%b cnt=%h want 0 %h", res_valid, blk_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [127:0] expq [$];
    logic [127:0] e;
    int sent, got, last_acc, n, lat;
    bit acc;
    lat = int'($urandom_range(1, 6)); core_lat = lat;
    res_ready = 1'b1; blk_valid = 1'b1; blk_data = rand128(); blk_encdec = 1'($urandom);
    sent = 0; got = 0; last_acc = 0; n = 0;
    while (got < N && n < 300) begin
      acc = (blk_valid === 1'b1) && (blk_ready === 1'b1);
      if (acc) begin
        if (sent > 0) begin
          total++;
          if (cyc - last_acc != lat + 3) begin
            bad++; $display("FAIL b2b_period: got %0d want %0d", cyc - last_acc, lat + 3);
          end
        end
        last_acc = cyc;
        expq.push_back(sm4_ref(cur_key, blk_data, blk_encdec));
        sent++;
      end
      tick(); n++;
      if (acc) begin
        if (sent < N) begin blk_data = rand128(); blk_encdec = 1'($urandom); end
        else blk_valid = 1'b0;
      end
      if (res_valid === 1'b1 && expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        if (res_data !== e) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", got, res_data, e); end
        got++;
      end
    end
    tick();
    res_ready = 1'b0; blk_valid = 1'b0;
    exp_count = exp_count + 16'(got);
    total++;
    if (got != N || blk_count !== exp_count) begin
      bad++; $display("FAIL b2b_total: results=%0d cnt=%h want %0d %h", got, blk_count, N, exp_count);
    end
  endtask

  task automatic test_random_blocks();
    logic [127:0] d, r, e;
    bit ed;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) load_key(rand128(), int'($urandom_range(1, 40)));
      core_lat = int'($urandom_range(1, 8));
      d = rand128(); ed = 1'($urandom);
      run_block(d, ed, int'($urandom_range(0, 3)), r);
      e = sm4_ref(cur_key, d, ed);
      total++;
      if (r !== e) begin bad++; $display("FAIL rand_block%0d: got %h want %h", i, r, e); end
    end
  endtask

  task automatic test_wrap();
    logic [127:0] r;
    force dut.blk_count_q = 16'hfffe;
    tick();
    release dut.blk_count_q;
    exp_count = 16'hfffe;
    core_lat = 2;
    run_block(rand128(), 1'b0, 0, r);
    run_block(rand128(), 1'b1, 0, r);
    total++;
    if (blk_count !== 16'h0000) begin bad++; $display("FAIL count_wrap: got %h want 0000", blk_count); end
  endtask

  task automatic test_reset_mid_crypt();
    int n;
    core_lat = 30;
    blk_data = rand128(); blk_encdec = 1'b0; blk_valid = 1'b1; n = 0;
    while (blk_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    blk_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0; key_load = 1'b1; key_in = rand128(); blk_valid = 1'b1; res_ready = 1'b1;
    tick();
    total++;
    if ({key_ack, key_ready, ke_en, ke_key, core_start, core_data, core_encdec,
         res_valid, res_data, err_timeout, blk_count} !== '0) begin
      bad++; $display("FAIL crypt_reset: ack=%b rdy=%b en=%b key=%h cdata=%h res=%h cnt=%h want all 0",
                      key_ack, key_ready, ke_en, ke_key, core_data, res_data, blk_count);
    end
    tick();
    total++;
    if ({blk_ready, key_ack, ke_en} !== 3'b000) begin
      bad++; $display("FAIL crypt_reset_hold: blk_ready=%b ack=%b en=%b want 0 0 0", blk_ready, key_ack, ke_en);
    end
    rst = 1'b1; key_load = 1'b0; blk_valid = 1'b0; res_ready = 1'b0;
    repeat (35) tick();
    total++;
    if ({key_ready, blk_ready, res_valid} !== 3'b000) begin
      bad++; $display("FAIL crypt_reset_idle: rdy=%b blk_ready=%b res_valid=%b want 0 0 0", key_ready, blk_ready, res_valid);
    end
  endtask

  initial begin
    rst = 1'b0; key_load = 1'b0; key_in = '0; blk_valid = 1'b0; blk_data = '0;
    blk_encdec = 1'b0; res_ready = 1'b0;
    test_reset();
    test_key_expand();
    test_known_vector();
    test_stray_done();
    test_key_reload();
    test_timeout();
    test_resp_hold();
    test_back_to_back();
    test_random_blocks();
    test_wrap();
    test_reset_mid_crypt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
